regfile_seq: RTL and testbench
==============================

// Module: regfile_seq
// PURPOSE
// - Command-driven initiator for the 2-read/1-write register file (writes share addr0 with read port 0).
// - Accepts one command at a time (valid/ready) and sequences the file's in/addr0/addr1/ctrw pins.
// - Runs multi-cycle ops (COPY, SWAP, CLEAR) and returns the operands' pre-op values (valid/ready).
// - Sits between the CPU control path and the register file; the register file is never driven elsewhere.
// PARAMETERS
// - NUM_REGS  16  registers in the attached file; CLEAR iterates 0..NUM_REGS-1
// - DATA_W    32  register data width
// - ADDR_W    8   register address width
// PORTS
// - clk        in   1       clock; all state updates on rising edge
// - rst        in   1       synchronous, active-high reset
// - cmd_valid  in   1       command present
// - cmd_ready  out  1       block idle, command accepted when valid&ready
// - cmd_op     in   3       0 READ, 1 WRITE_IMM, 2 COPY (ra<=rb), 3 SWAP, 4 CLEAR; 5-7 illegal
// - cmd_ra     in   ADDR_W  operand A / write-destination address
// - cmd_rb     in   ADDR_W  operand B / copy-source address
// - cmd_imm    in   DATA_W  WRITE_IMM data
// - rsp_valid  out  1       response held until rsp_ready
// - rsp_ready  in   1       consumer accepts response
// - rsp_d0     out  DATA_W  pre-op value of ra
// - rsp_d1     out  DATA_W  pre-op value of rb
// - rsp_err    out  1       illegal opcode (or bounds violation, see CONFIGURATION)
// - rf_in      out  DATA_W  register-file write data
// - rf_addr0   out  ADDR_W  register-file read0/write address
// - rf_addr1   out  ADDR_W  register-file read1 address
// - rf_ctrw    out  1       register-file write enable (1 = write addr0 at next edge)
// - rf_out0    in   DATA_W  register-file read data 0 (combinational from rf_addr0)
// - rf_out1    in   DATA_W  register-file read data 1 (combinational from rf_addr1)
// BEHAVIOUR
// - Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_d0/d1=0, rsp_err=0, clear counter=0.
// - rf_ctrw is combinationally 0 whenever rst=1. Reset mid-op abandons the op (a SWAP may be half-done).
// - rf_* outputs decode from registered state and latched command only; no path from cmd_*/rsp_ready.
// - Outside write states: rf_ctrw=0, rf_in=0; rf_addr0/1 hold the latched ra/rb.
// - States / transitions:
//   IDLE: cmd_ready=1; on handshake latch op/ra/rb/imm -> EXEC.
//   EXEC: addr0=ra, addr1=rb, ctrw=0; capture rf_out0->t0 and rf_out1->t1 (drive rsp_d0/d1).
//     READ or illegal -> RSP; WRITE_IMM/COPY/SWAP -> WR_A; CLEAR -> CLR.
//   WR_A: addr0=ra, ctrw=1, in = imm (WRITE_IMM) or t1 (COPY/SWAP); SWAP -> WR_B, else -> RSP.
//   WR_B: addr0=rb, ctrw=1, in=t0 -> RSP.
//   CLR: addr0=cnt, in=0, ctrw=1; cnt++ each cycle; after cnt==NUM_REGS-1, cnt<=0 -> RSP.
//   RSP: rsp_valid=1, outputs stable; on rsp_ready -> IDLE (next command accepted one cycle later).
// - Latency, accept edge to rsp_valid: READ 2, WRITE_IMM/COPY 3, SWAP 4, CLEAR 2+NUM_REGS cycles.
// - SWAP with ra==rb: both writes occur and the value is unchanged. COPY with ra==rb rewrites the same value.
// - Illegal opcode: no write cycles, rsp_err=1, rsp_d0/d1 still return read data.
// - Addresses are ADDR_W wide; out-of-range reads return the file's default (0) and out-of-range writes are ignored by the file.
// CONFIGURATION
// - REGFILE_SEQ_BOUNDS_CHECK_EN defined: any ra/rb >= NUM_REGS used by the op
//   (READ/COPY/SWAP: ra and rb; WRITE_IMM: ra) skips all write states, goes EXEC->RSP, rsp_err=1.
// - Undefined: addresses pass through unchecked; rsp_err flags illegal opcodes only.
// STRUCTURE
// - Package regfile_seq_pkg: op encodings (OP_READ..OP_CLEAR), state enum, default widths.
// - Single module. The clear counter and the t0/t1 capture registers are inline; no sub-module.
// TESTING
// - WRITE_IMM ra=3 imm=0xDEADBEEF, then READ ra=3 rb=0 -> rsp_d0=0xDEADBEEF, rsp_d1=0, rsp_valid 2 cycles after accept.
// - r5=0x11, r9=0x22; SWAP ra=5 rb=9 -> rsp_d0=0x11 d1=0x22; re-READ gives r5=0x22, r9=0x11; rsp at +4.
// - COPY ra=2 rb=7 (r7=0xA5A5) -> r2=0xA5A5; rf_ctrw high exactly 1 cycle with rf_addr0=2.
// - CLEAR after filling r0..r15 -> rf_ctrw high 16 consecutive cycles, addr0 0..15; all reads 0; rsp at +18.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0; op=6 -> rsp_err=1, no write.
// - rst during WR_B of a SWAP -> rf_ctrw=0 that cycle, IDLE next, cmd_ready=1; with BOUNDS_CHECK_EN, WRITE_IMM ra=20 -> err=1, no ctrw.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Package: regfile_seq_pkg
// Purpose : Shared opcode encodings, sequencer state encoding and default
//           widths for the regfile_seq command sequencer.
package regfile_seq_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 8;

  // Opcodes 5..7 are left unnamed on purpose; they decode as illegal.
  typedef enum logic [2:0] {
    OP_READ      = 3'd0,
    OP_WRITE_IMM = 3'd1,
    OP_COPY      = 3'd2,
    OP_SWAP      = 3'd3,
    OP_CLEAR     = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WR_A,
    S_WR_B,
    S_CLR,
    S_RSP
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_CLEAR;
  endfunction

endpackage

// File: rtl/regfile_seq.sv
// Module : regfile_seq
// Purpose: Command-driven initiator for a 2-read/1-write register file.
//          Accepts one command at a time, sequences the file's pins through
//          READ / WRITE_IMM / COPY / SWAP / CLEAR, and returns the operands'
//          pre-op values on a valid/ready response channel.
// Ports  :
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_ra, cmd_rb, cmd_imm   command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_d0, rsp_d1, rsp_err       pre-op values of ra/rb, error flag
//   rf_in, rf_addr0, rf_addr1, rf_ctrw   register-file drive
//   rf_out0, rf_out1              register-file read data (combinational)
// Config : define REGFILE_SEQ_BOUNDS_CHECK_EN to reject commands whose used
//          addresses are >= NUM_REGS (no writes, rsp_err=1).
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_d0,
  output logic [DATA_W-1:0] rsp_d1,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rf_in,
  output logic [ADDR_W-1:0] rf_addr0,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic              rf_ctrw,
  input  logic [DATA_W-1:0] rf_out0,
  input  logic [DATA_W-1:0] rf_out1
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_ra;
  logic [ADDR_W-1:0]   r_rb;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_t0;
  logic [DATA_W-1:0]   r_t1;
  logic                r_err;
  logic [ADDR_W-1:0]   r_cnt;
  logic                w_err;
  logic                w_oob;

`ifdef REGFILE_SEQ_BOUNDS_CHECK_EN
  logic w_uses_rb;
  // CLEAR ignores ra/rb entirely, WRITE_IMM only uses ra.
  assign w_uses_rb = (r_op == OP_READ) || (r_op == OP_COPY) || (r_op == OP_SWAP);
  assign w_oob     = (r_op != OP_CLEAR) &&
                     ((r_ra >= ADDR_W'(NUM_REGS)) || (w_uses_rb && (r_rb >= ADDR_W'(NUM_REGS))));
`else
  assign w_oob = 1'b0;
`endif

  assign w_err = !op_is_legal(r_op) || w_oob;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_imm   <= '0;
      r_t0    <= '0;
      r_t1    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op  <= cmd_op;
            r_ra  <= cmd_ra;
            r_rb  <= cmd_rb;
            r_imm <= cmd_imm;
          end
        end
        S_EXEC: begin
          // Pre-op snapshot: these become both the response data and the
          // values written back by COPY/SWAP.
          r_t0  <= rf_out0;
          r_t1  <= rf_out1;
          r_err <= w_err;
        end
        S_CLR:   r_cnt <= (r_cnt == LAST_REG) ? '0 : r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_err) begin
          w_next_state = S_RSP;
        end else begin
          case (r_op)
            OP_WRITE_IMM, OP_COPY, OP_SWAP: w_next_state = S_WR_A;
            OP_CLEAR:                       w_next_state = S_CLR;
            default:                        w_next_state = S_RSP;
          endcase
        end
      end
      S_WR_A:  w_next_state = (r_op == OP_SWAP) ? S_WR_B : S_RSP;
      S_WR_B:  w_next_state = S_RSP;
      S_CLR:   if (r_cnt == LAST_REG) w_next_state = S_RSP;
      S_RSP:   if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    rf_addr0 = r_ra;
    rf_addr1 = r_rb;
    rf_in    = '0;
    rf_ctrw  = 1'b0;
    case (r_state)
      S_WR_A: begin
        rf_ctrw = 1'b1;
        rf_in   = (r_op == OP_WRITE_IMM) ? r_imm : r_t1;
      end
      S_WR_B: begin
        rf_ctrw  = 1'b1;
        rf_addr0 = r_rb;
        rf_in    = r_t0;
      end
      S_CLR: begin
        rf_ctrw  = 1'b1;
        rf_addr0 = r_cnt;
      end
      default: ;
    endcase
    // The state register only clears at the edge, so gate the write strobe
    // directly to keep a reset cycle from committing a write.
    if (rst) rf_ctrw = 1'b0;
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_d0    = r_t0;
  assign rsp_d1    = r_t1;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_ra;
  logic [7:0]  cmd_rb;
  logic [31:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_d0;
  logic [31:0] rsp_d1;
  logic        rsp_err;
  logic [31:0] rf_in;
  logic [7:0]  rf_addr0;
  logic [7:0]  rf_addr1;
  logic        rf_ctrw;
  logic [31:0] rf_out0;
  logic [31:0] rf_out1;

  regfile_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d0(rsp_d0), .rsp_d1(rsp_d1), .rsp_err(rsp_err),
    .rf_in(rf_in), .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_ctrw(rf_ctrw),
    .rf_out0(rf_out0), .rf_out1(rf_out1)
  );

  always #5 clk = ~clk;

  // Behavioural 16-entry register file: out-of-range reads give 0,
  // out-of-range writes are dropped.
  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  assign rf_out0 = (rf_addr0 < 8'd16) ? mem[rf_addr0[3:0]] : '0;
  assign rf_out1 = (rf_addr1 < 8'd16) ? mem[rf_addr1[3:0]] : '0;
  always @(posedge clk) if (rf_ctrw && rf_addr0 < 8'd16) mem[rf_addr0[3:0]] <= rf_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nfail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_done = 0;
  int   last_acc = 0;

  // Write log, sampled late in the low phase so a write squashed by rst
  // in the same cycle is not recorded.
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  initial forever begin
    @(negedge clk);
    #4;
    if (rf_ctrw === 1'b1) begin
      wa_q.push_back(rf_addr0);
      wd_q.push_back(rf_in);
      wc_q.push_back(cyc);
    end
  end

  // Response monitor / scoreboard
  initial begin : monitor
    logic        held;
    int          first_cyc;
    logic [31:0] h_d0, h_d1;
    logic        h_err;
    exp_t        e;
    held = 1'b0;
    first_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (!held) begin
          first_cyc = cyc;
          h_d0 = rsp_d0;
          h_d1 = rsp_d1;
          h_err = rsp_err;
        end else begin
          check("hold_d0", rsp_d0, h_d0);
          check("hold_d1", rsp_d1, h_d1);
          check("hold_err", rsp_err, h_err);
          check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_d0", rsp_d0, e.d0);
            check("rsp_d1", rsp_d1, e.d1);
            check("rsp_err", rsp_err, e.err);
            check("rsp_latency", first_cyc - e.acc, e.lat);
          end
          rsp_done++;
        end
        held = !rsp_ready;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] ra, input logic [7:0] rb,
                          input logic [31:0] imm, input logic [31:0] d0, input logic [31:0] d1,
                          input logic err, input int lat, input bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 1'b1, 1'b0);
    end else begin
      last_acc = cyc;
      if (push) begin
        e.d0 = d0; e.d1 = d1; e.err = err; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int start;
    start = rsp_done;
    for (int i = 0; i < 100 && rsp_done == start; i++) @(negedge clk);
    if (rsp_done == start) check("rsp_timeout", 1'b1, 1'b0);
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] ra, input logic [7:0] rb,
                     input logic [31:0] imm, input logic [31:0] d0, input logic [31:0] d1,
                     input logic err, input int lat);
    send_cmd(op, ra, rb, imm, d0, d1, err, lat, 1'b1);
    wait_rsp();
  endtask

  task automatic check_writes(input string name, input int n, input logic [7:0] a0,
                              input logic [31:0] d0, input logic [7:0] a1, input logic [31:0] d1);
    check({name, "_count"}, wa_q.size(), n);
    if (n >= 1 && wa_q.size() >= 1) begin
      check({name, "_a0"}, wa_q[0], a0);
      check({name, "_d0"}, wd_q[0], d0);
    end
    if (n >= 2 && wa_q.size() >= 2) begin
      check({name, "_a1"}, wa_q[1], a1);
      check({name, "_d1"}, wd_q[1], d1);
    end
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  function automatic logic [31:0] prefill(input int i);
    case (i)
      2:       return 32'hA5A5;
      3:       return 32'hDEADBEEF;
      5:       return 32'h22;
      7:       return 32'hA5A5;
      9:       return 32'h11;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    bit ok;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_d0", rsp_d0, 32'h0);
    check("rst_rsp_d1", rsp_d1, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_ctrw", rf_ctrw, 1'b0);
    wa_q.delete(); wd_q.delete(); wc_q.delete();

    // WRITE_IMM then READ
    run(3'd1, 8'd3, 8'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 3);
    check_writes("wimm", 1, 8'd3, 32'hDEADBEEF, 8'd0, 32'h0);
    run(3'd0, 8'd3, 8'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check_writes("read", 0, 8'd0, 32'h0, 8'd0, 32'h0);

    // SWAP
    run(3'd1, 8'd5, 8'd0, 32'h11, 32'h0, 32'h0, 1'b0, 3);
    run(3'd1, 8'd9, 8'd0, 32'h22, 32'h0, 32'h0, 1'b0, 3);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    run(3'd3, 8'd5, 8'd9, 32'h0, 32'h11, 32'h22, 1'b0, 4);
    check_writes("swap", 2, 8'd5, 32'h22, 8'd9, 32'h11);
    run(3'd0, 8'd5, 8'd9, 32'h0, 32'h22, 32'h11, 1'b0, 2);

    // COPY
    run(3'd1, 8'd7, 8'd0, 32'hA5A5, 32'h0, 32'h0, 1'b0, 3);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    run(3'd2, 8'd2, 8'd7, 32'h0, 32'h0, 32'hA5A5, 1'b0, 3);
    check_writes("copy", 1, 8'd2, 32'hA5A5, 8'd0, 32'h0);
    run(3'd0, 8'd2, 8'd7, 32'h0, 32'hA5A5, 32'hA5A5, 1'b0, 2);

    // SWAP with ra==rb: two writes of the unchanged value
    run(3'd3, 8'd9, 8'd9, 32'h0, 32'h11, 32'h11, 1'b0, 4);
    check_writes("swap_same", 2, 8'd9, 32'h11, 8'd9, 32'h11);

    // Back-pressure: response held 5 cycles
    @(posedge clk); #1 rsp_ready = 1'b0;
    send_cmd(3'd0, 8'd3, 8'd5, 32'h0, 32'hDEADBEEF, 32'h22, 1'b0, 2, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) check("hold_rsp_timeout", 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp();

    // Illegal opcode: error, read data returned, no write
    run(3'd6, 8'd3, 8'd5, 32'h77, 32'hDEADBEEF, 32'h22, 1'b1, 2);
    check_writes("illegal", 0, 8'd0, 32'h0, 8'd0, 32'h0);

    // Fill r0..r15, then CLEAR
    for (int i = 0; i < 16; i++)
      run(3'd1, 8'(i), 8'(i), 32'h100 + 32'(i), prefill(i), prefill(i), 1'b0, 3);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    run(3'd4, 8'd0, 8'd1, 32'h0, 32'h100, 32'h101, 1'b0, 18);
    check("clr_count", wa_q.size(), 16);
    if (wa_q.size() == 16) begin
      check("clr_first_cycle", wc_q[0], last_acc + 2);
      for (int i = 0; i < 16; i++) begin
        check("clr_addr", wa_q[i], 8'(i));
        check("clr_data", wd_q[i], 32'h0);
        check("clr_consecutive", wc_q[i], wc_q[0] + i);
      end
    end
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    for (int i = 0; i < 16; i++)
      run(3'd0, 8'(i), 8'(15 - i), 32'h0, 32'h0, 32'h0, 1'b0, 2);

    // Out-of-range WRITE_IMM
`ifdef REGFILE_SEQ_BOUNDS_CHECK_EN
    run(3'd1, 8'd20, 8'd0, 32'h55, 32'h0, 32'h0, 1'b1, 2);
    check_writes("oob", 0, 8'd0, 32'h0, 8'd0, 32'h0);
`else
    run(3'd1, 8'd20, 8'd0, 32'h55, 32'h0, 32'h0, 1'b0, 3);
    check_writes("oob", 1, 8'd20, 32'h55, 8'd0, 32'h0);
`endif

    // Reset during WR_B of a SWAP: first half lands, second is dropped
    run(3'd1, 8'd5, 8'd0, 32'h11, 32'h0, 32'h0, 1'b0, 3);
    run(3'd1, 8'd9, 8'd0, 32'h22, 32'h0, 32'h0, 1'b0, 3);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    send_cmd(3'd3, 8'd5, 8'd9, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (cyc == last_acc + 3) ok = 1'b1;
    end
    if (!ok) check("wrb_wait_timeout", 1'b1, 1'b0);
    check("wrb_ctrw", rf_ctrw, 1'b1);
    check("wrb_addr0", rf_addr0, 8'd9);
    #1 rst = 1'b1;
    #1 check("rst_ctrw_gate", rf_ctrw, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check_writes("half_swap", 1, 8'd5, 32'h22, 8'd0, 32'h0);
    run(3'd0, 8'd5, 8'd9, 32'h0, 32'h22, 32'h22, 1'b0, 2);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
